// File: rtl/ram_snap_pkg.sv
// Shared definitions for the RAM snapshot sequencer: FSM state encoding.
package ram_snap_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE       = 3'd0,
    DUMP_PRIME = 3'd1,
    DUMP       = 3'd2,
    RESTORE    = 3'd3,
    FINISH     = 3'd4
  } state_t;

endpackage

// File: rtl/ram_snap_cksum.sv
// Running modulo-2**DATA_WIDTH sum of migrated words (clear on start, add on enable).
// Only compiled when RAM_SNAP_CHECKSUM_EN is defined.
`ifdef RAM_SNAP_CHECKSUM_EN
module ram_snap_cksum #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] sum
);

  // Accumulator; clear wins over a same-cycle add.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
    end else if (clr) begin
      sum <= '0;
    end else if (en) begin
      sum <= sum + data;
    end
  end

endmodule
`endif

// File: rtl/ram_snapshot_ctrl.sv
// Sequencer in front of a write-first block RAM: user access passthrough in IDLE,
// DUMP streams every entry out, RESTORE writes an incoming stream back.
// Optional feature macro: RAM_SNAP_CHECKSUM_EN (adds chk output and chk_ref compare).
module ram_snapshot_ctrl
  import ram_snap_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned WORDS      = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef RAM_SNAP_CHECKSUM_EN
  output logic [DATA_WIDTH-1:0] chk,
  input  logic [DATA_WIDTH-1:0] chk_ref,
`endif
  input  logic                  usr_we,
  input  logic [ADDR_WIDTH-1:0] usr_w_addr,
  input  logic [DATA_WIDTH-1:0] usr_w_data,
  input  logic [ADDR_WIDTH-1:0] usr_r_addr,
  output logic [DATA_WIDTH-1:0] usr_r_data,
  output logic                  usr_stall,
  input  logic                  dump_start,
  input  logic                  restore_start,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] dout_data,
  output logic                  dout_last,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  input  logic [DATA_WIDTH-1:0] din_data,
  input  logic                  din_last,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_w_addr,
  output logic [DATA_WIDTH-1:0] ram_w_data,
  output logic [ADDR_WIDTH-1:0] ram_r_addr,
  input  logic [DATA_WIDTH-1:0] ram_r_data
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = ADDR_WIDTH'(1);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    err_q, err_d;

  // Read data is never re-registered: dump data tracks the held read address.
  assign usr_r_data = ram_r_data;
  assign dout_data  = ram_r_data;
  assign err        = err_q;

`ifdef RAM_SNAP_CHECKSUM_EN
  logic dump_fire;
  logic rest_acc;
  logic start_clr;
  logic restore_op_q;

  assign dump_fire = (state_q == DUMP) & dout_ready;
  assign rest_acc  = (state_q == RESTORE) & din_valid;
  assign start_clr = (state_q == IDLE) & (dump_start | restore_start);

  // Remember which operation is running so FINISH only checks restores.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      restore_op_q <= 1'b0;
    end else if (start_clr) begin
      restore_op_q <= ~dump_start;
    end
  end

  ram_snap_cksum #(.DATA_WIDTH(DATA_WIDTH)) u_cksum (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_clr),
    .en    (dump_fire | rest_acc),
    .data  (dump_fire ? ram_r_data : din_data),
    .sum   (chk)
  );
`endif

  // State, address counter and sticky error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic and RAM/stream port muxing.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    ram_we     = 1'b0;
    ram_w_addr = usr_w_addr;
    ram_w_data = usr_w_data;
    ram_r_addr = usr_r_addr;
    busy       = (state_q != IDLE);
    done       = 1'b0;
    usr_stall  = (state_q != IDLE) & usr_we;
    dout_valid = 1'b0;
    dout_last  = 1'b0;
    din_ready  = 1'b0;

    unique case (state_q)
      IDLE: begin
        ram_we = usr_we & rst_n;
        if (dump_start) begin
          state_d = DUMP_PRIME;
          cnt_d   = '0;
          err_d   = 1'b0;
        end else if (restore_start) begin
          state_d = RESTORE;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end

      DUMP_PRIME: begin
        ram_r_addr = '0;
        state_d    = DUMP;
      end

      DUMP: begin
        dout_valid = 1'b1;
        dout_last  = (cnt_q == LAST_IDX);
        if (dout_ready) begin
          ram_r_addr = cnt_q + CNT_ONE;
          if (dout_last) begin
            state_d = FINISH;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          ram_r_addr = cnt_q;
        end
      end

      RESTORE: begin
        din_ready = 1'b1;
        if (din_valid) begin
          ram_we     = 1'b1;
          ram_w_addr = cnt_q;
          ram_w_data = din_data;
          if (din_last || (cnt_q == LAST_IDX)) begin
            state_d = FINISH;
            err_d   = err_q | (din_last != (cnt_q == LAST_IDX));
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
`ifdef RAM_SNAP_CHECKSUM_EN
        if (restore_op_q && (chk != chk_ref)) begin
          err_d = 1'b1;
        end
`endif
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: doc/ram_snapshot_ctrl.md
Name: ram_snapshot_ctrl

Overview:
Sequencer placed in front of one simple dual-port write-first block RAM (one clock, registered read address, read data valid one cycle after the address). It muxes normal user access with two migration operations: a DUMP that streams all WORDS entries out over a valid/ready stream, and a RESTORE that writes an incoming stream back into the RAM. It is used to capture and reload memory state during live migration.

Parameters:
ADDR_WIDTH, 12, RAM address width.
DATA_WIDTH, 32, RAM word width.
WORDS, 4096, number of RAM entries; must satisfy 2 <= WORDS <= 2**ADDR_WIDTH.

Ports:
clk  in  1  single clock.
rst_n  in  1  asynchronous active-low reset.
usr_we / usr_w_addr / usr_w_data / usr_r_addr  in  1/ADDR_WIDTH/DATA_WIDTH/ADDR_WIDTH  user RAM access.
usr_r_data  out  DATA_WIDTH  RAM read data passthrough.
usr_stall  out  1  high while a user request is blocked (busy).
dump_start / restore_start  in  1  single-cycle command pulses.
busy  out  1  high in any state other than IDLE.
done  out  1  one-cycle pulse when an operation completes.
err  out  1  sticky restore length error; cleared by the next start.
dout_data / dout_last / dout_valid  out  DATA_WIDTH/1/1  dump stream.
dout_ready  in  1  dump stream ready.
din_data / din_last / din_valid  in  DATA_WIDTH/1/1  restore stream.
din_ready  out  1  restore stream ready.
ram_we / ram_w_addr / ram_w_data / ram_r_addr  out  1/ADDR_WIDTH/DATA_WIDTH/ADDR_WIDTH  to RAM.
ram_r_data  in  DATA_WIDTH  from RAM.

Behaviour:
- Reset (async, rst_n low): state IDLE; busy, done, err, dout_valid, din_ready, ram_we and usr_stall all 0; address counter 0. RAM contents are not touched. Reset during DUMP or RESTORE aborts the operation immediately with no done pulse.
- FSM states: IDLE, DUMP_PRIME, DUMP, RESTORE, FINISH.
- IDLE: ram_* ports are driven directly from usr_*. usr_r_data = ram_r_data in all states. dump_start moves to DUMP_PRIME. restore_start moves to RESTORE. If both pulse in the same cycle, dump wins and restore_start is dropped. Both starts clear err and the counter.
- Starts arriving in any state other than IDLE are ignored.
- Non-IDLE states: ram_we from the user is suppressed and usr_stall = usr_we (user reads proceed, but the returned data is unspecified).
- DUMP_PRIME (1 cycle): ram_r_addr = 0, then go to DUMP.
- DUMP: dout_valid = 1 and dout_data = ram_r_data, combinational with no extra register.
  - A fire is dout_valid & dout_ready.
  - ram_r_addr = cnt+1 on a fire, else cnt. This holds the read address so the data stays stable under backpressure.
  - On a fire, cnt increments. dout_last = (cnt == WORDS-1).
  - Fire with last moves to FINISH. There are no bubbles: 1 word/cycle at full ready. First valid appears 2 cycles after dump_start.
- RESTORE: din_ready = 1. On din_valid: ram_we = 1, ram_w_addr = cnt, ram_w_data = din_data, and cnt increments.
  - If din_last arrives with cnt != WORDS-1: set err, go to FINISH; the remaining entries are untouched.
  - If cnt == WORDS-1 without din_last: write the word, set err, go to FINISH.
  - Normal end: din_last with cnt == WORDS-1 goes to FINISH with err = 0.
- FINISH (1 cycle): done = 1, then return to IDLE. busy stays high through FINISH.
- Counter width is ADDR_WIDTH. It never wraps because termination occurs at WORDS-1.

Optional Feature:
RAM_SNAP_CHECKSUM_EN.
- Defined: adds output chk [DATA_WIDTH-1:0], a running sum modulo 2**DATA_WIDTH of every fired dump word or accepted restore word. It is cleared at start and held after done.
- Restore also compares against input chk_ref [DATA_WIDTH-1:0] in FINISH. A mismatch sets err.
- Undefined: the chk and chk_ref ports are absent and there is no adder.

Decomposition:
- Shared package ram_snap_pkg holds the FSM state enum (IDLE, DUMP_PRIME, DUMP, RESTORE, FINISH) and its state width constant.
- Optional sub-module ram_snap_cksum (accumulator with clear and enable) is instantiated only under the macro.
- The RAM itself is instantiated outside this block.

Test Plan:
All cases use WORDS=8, ADDR_WIDTH=3, DATA_WIDTH=32, with a real write-first RAM model attached.
- Preload via user port (addr i := 0x100+i), dump_start with dout_ready=1 -> dout values 0x100..0x107 on 8 consecutive cycles, first valid 2 cycles after start, dout_last on 0x107, done 1 cycle later.
- Dump with dout_ready toggling 1,0,0,1,... -> no duplicate or missing words, dout_data stable while stalled, same 8-value sequence.
- Restore 8 words 0xA0..0xA7 with din_valid gaps, din_last on the 8th -> RAM holds 0xA0..0xA7, err=0, done pulses once.
- Restore with din_last on the 5th word -> addr 0-4 written, addr 5-7 keep old data, err=1 until the next start.
- dump_start and restore_start in the same cycle -> dump runs, nothing written. usr_we during busy -> usr_stall=1 and the write is suppressed.
- rst_n low mid-dump at word 3 -> outputs at reset values immediately; a new dump afterwards restarts at word 0.
